// File: rtl/display_scan_if.sv
// Bus between the calculator datapath and the display scan controller.
// The controller sits on the slave modport; the datapath/bench uses master.
interface display_scan_if;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  digit_en;
  logic        load_ack;
  logic        frame_start;
  logic [1:0]  digit_sel;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  modport master (
    output value_in, load, digit_en,
    input  load_ack, frame_start, digit_sel, an_n, seg_n
  );

  modport slave (
    input  value_in, load, digit_en,
    output load_ack, frame_start, digit_sel, an_n, seg_n
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit seven-segment scan controller with anti-ghost blanking and frame-aligned double buffering.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3..1.
module display_scan_ctrl #(
  parameter int TICK_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  display_scan_if.slave bus
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam bit HAS_BLANK = (BLANK_CYCLES != 0);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;
  localparam logic [0:0] ST_INIT  = HAS_BLANK ? ST_BLANK : ST_DRIVE;

  logic [CNT_W-1:0] tick_cnt;
  logic [1:0]       digit_sel;
  logic [0:0]       state;
  logic [15:0]      shadow;
  logic [15:0]      pending;
  logic             pend_valid;
  logic             slot_wrap;
  logic             frame_wrap;
  logic [3:0]       nibble;
  logic             lead_zero;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign slot_wrap  = (tick_cnt == TICK_LAST);
  assign frame_wrap = slot_wrap && (digit_sel == 2'd3);
  assign nibble     = shadow[{digit_sel, 2'b00} +: 4];
  assign bus.digit_sel = digit_sel;

`ifdef LEADING_ZERO_BLANK_EN
  // Digit 0 is never suppressed so an all-zero value still shows "0".
  always_comb begin
    lead_zero = 1'b0;
    case (digit_sel)
      2'd1:    lead_zero = (shadow[15:4] == 12'h000);
      2'd2:    lead_zero = (shadow[15:8] == 8'h00);
      2'd3:    lead_zero = (shadow[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
  end
`else
  assign lead_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      digit_sel <= 2'd0;
    end else if (slot_wrap) begin
      tick_cnt  <= '0;
      digit_sel <= digit_sel + 2'd1;
    end else begin
      tick_cnt  <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
    end else if (slot_wrap) begin
      state <= ST_INIT;
    end else if (HAS_BLANK && state == ST_BLANK && tick_cnt == BLANK_LAST) begin
      state <= ST_DRIVE;
    end
  end

  // Outputs lag state/digit_sel by one cycle so the pins come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an_n  <= 4'hF;
      bus.seg_n <= 7'h7F;
    end else if (state == ST_DRIVE) begin
      bus.an_n  <= bus.digit_en[digit_sel] ? ~(4'b0001 << digit_sel) : 4'hF;
      bus.seg_n <= lead_zero ? 7'h7F : hex_to_seg(nibble);
    end else begin
      bus.an_n  <= 4'hF;
      bus.seg_n <= 7'h7F;
    end
  end

  // A load landing exactly on the frame boundary bypasses pending and wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow          <= 16'h0000;
      pending         <= 16'h0000;
      pend_valid      <= 1'b0;
      bus.load_ack    <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= frame_wrap;
      bus.load_ack    <= 1'b0;
      if (frame_wrap && bus.load) begin
        shadow       <= bus.value_in;
        pend_valid   <= 1'b0;
        bus.load_ack <= 1'b1;
      end else if (frame_wrap && pend_valid) begin
        shadow       <= pending;
        pend_valid   <= 1'b0;
        bus.load_ack <= 1'b1;
      end else if (bus.load) begin
        pending      <= bus.value_in;
        pend_valid   <= 1'b1;
      end
    end
  end

endmodule
